// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM state
// encoding, the slice width and a sizing helper for the nibble index.
package nsa_pkg;

  // Controller states; the encoding is fixed so traces stay readable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  // Width of the single adder slice the controller time-shares.
  localparam int NIB_BITS = 4;

  // Ceiling log2, used for sizing the nibble index counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << result) < value) begin
        result = result + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Purely combinational 4-bit adder slice with carry in and carry out.
// The controller owns all state; this block only does the arithmetic.
module nibble_add_slice
  import nsa_pkg::*;
(
  input  logic [NIB_BITS-1:0] a,
  input  logic [NIB_BITS-1:0] b,
  input  logic                cin,
  output logic [NIB_BITS-1:0] s,
  output logic                cout
);

  // Widen by one bit so the slice carry falls out of the top of the sum.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIB_BITS{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder controller: adds two WIDTH-bit operands through one
// shared 4-bit slice, one nibble per clock, LSB nibble first, with
// valid/ready handshakes on both the operand and result sides.
// Optional build macro: SUB_MODE_EN adds a 'sub' input that turns the
// operation into a - b (B stored inverted, initial carry 1).
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Number of nibble steps and the index width; a single-nibble build still
  // needs a one-bit index so the counter never collapses to zero width.
  localparam int NIB   = WIDTH / NIB_BITS;
  localparam int IDX_W = (clog2(NIB) < 1) ? 1 : clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  nsa_state_e r_state;
  logic [NIB-1:0][NIB_BITS-1:0] r_a;
  logic [NIB-1:0][NIB_BITS-1:0] r_b;
  logic [NIB-1:0][NIB_BITS-1:0] r_sum;
  logic [IDX_W-1:0] r_idx;
  logic r_carry;
  logic r_cout;
  logic r_opReady;
  logic r_resValid;
  logic r_busy;

  logic [NIB_BITS-1:0] w_sliceSum;
  logic w_sliceCarry;

  // The one shared slice always works on the nibble selected by the index.
  nibble_add_slice u_slice (
    .a    (r_a[r_idx]),
    .b    (r_b[r_idx]),
    .cin  (r_carry),
    .s    (w_sliceSum),
    .cout (w_sliceCarry)
  );

  // Controller FSM with registered handshake outputs; reset aborts any
  // operation in flight and leaves nothing flagged valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_opReady  <= 1'b1;
      r_resValid <= 1'b0;
      r_busy     <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (op_valid && r_opReady) begin
            r_a <= a;
`ifdef SUB_MODE_EN
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
`else
            r_b     <= b;
            r_carry <= 1'b0;
`endif
            r_idx     <= '0;
            r_opReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_sum[r_idx] <= w_sliceSum;
          r_carry      <= w_sliceCarry;
          if (r_idx == LAST_IDX) begin
            r_cout     <= w_sliceCarry;
            r_resValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
            r_opReady  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_resValid <= 1'b0;
          r_opReady  <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign op_ready  = r_opReady;
  assign res_valid = r_resValid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (WIDTH=16): table-driven vectors, a
// few hand-written multi-cycle sequences and randomized operations checked
// against a plain-arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int totalChecks;
  int badChecks;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] expSum;
    logic             expCout;
  } vec_t;

  vec_t vecs[$];

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .a         (a),
    .b         (b),
`ifdef SUB_MODE_EN
    .sub       (sub),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                               input logic ss, input logic rr);
    op_valid  = v;
    a         = aa;
    b         = bb;
    sub       = ss;
    res_ready = rr;
  endtask

  // Reference: addition is (WIDTH+1)-bit arithmetic; subtraction is a - b
  // modulo 2^WIDTH with cout meaning "no borrow".
  function automatic void refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                                   output logic [WIDTH-1:0] r, output logic c);
    int unsigned full;
    if (s) begin
      r = x - y;
      c = (x >= y);
    end else begin
      full = int'(x) + int'(y);
      r = full[WIDTH-1:0];
      c = full[WIDTH];
    end
  endfunction

  // One full transaction from IDLE back to IDLE; called at a negedge.
  task automatic runOp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic ts,
                       input logic [WIDTH-1:0] expSum, input logic expCout, input logic early,
                       input string tag);
    int lat;
    checkOutput({tag, "_idle_ready"}, op_ready, 1);
    applyStimulus(1'b1, ta, tb, ts, early);
    @(negedge clk);
    applyStimulus(1'b0, WIDTH'($urandom), WIDTH'($urandom), ~ts, early);
    checkOutput({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!res_valid && lat < 20) begin
      checkOutput({tag, "_run_opready"}, op_ready, 0);
      @(negedge clk);
      lat++;
    end
    // Counting the accept edge as edge 1, res_valid appears after edge NIB+1.
    checkOutput({tag, "_latency"}, lat, NIB);
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_cout"}, cout, expCout);
    checkOutput({tag, "_done_opready"}, op_ready, 0);
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_ret_resvalid"}, res_valid, 0);
    checkOutput({tag, "_ret_opready"}, op_ready, 1);
    checkOutput({tag, "_ret_busy"}, busy, 0);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] rs;
    logic rc;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rsub;
    logic [WIDTH-1:0] prevSum;
    int unsigned mask;
    int lat;

    totalChecks = 0;
    badChecks   = 0;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0});
`ifdef SUB_MODE_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1});
`endif

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_opready", op_ready, 1);
    checkOutput("reset_resvalid", res_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].expSum, vecs[i].expCout,
            logic'(i % 2), $sformatf("vec%0d", i));
    end

    $display("[TB] ripple with per-nibble progression");
    runOp(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1, "pre_ripple");
    prevSum = 16'h5555;
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int k = 1; k <= NIB; k++) begin
      @(negedge clk);
      mask = (32'd1 << (4 * k)) - 32'd1;
      checkOutput($sformatf("ripple_step%0d_sum", k), sum, prevSum & ~WIDTH'(mask));
    end
    checkOutput("ripple_resvalid", res_valid, 1);
    checkOutput("ripple_cout", cout, 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    $display("[TB] backpressure in DONE");
    applyStimulus(1'b1, 16'h00F0, 16'h0010, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("bp_latency", lat, NIB);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("bp_resvalid", res_valid, 1);
      checkOutput("bp_opready", op_ready, 0);
      checkOutput("bp_sum", sum, 16'h0100);
      checkOutput("bp_cout", cout, 0);
      checkOutput("bp_busy", busy, 1);
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp_release_resvalid", res_valid, 0);
    checkOutput("bp_release_opready", op_ready, 1);
    checkOutput("bp_release_busy", busy, 0);
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_no_stray_accept", busy, 0);

    $display("[TB] asynchronous reset during RUN");
    applyStimulus(1'b1, 16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_sum", sum, 0);
    checkOutput("arst_cout", cout, 0);
    checkOutput("arst_resvalid", res_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_opready", op_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runOp(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, "post_reset");

    $display("[TB] back-to-back with op_valid held");
    begin
      int cyc;
      int accepts[$];
      int handshakes[$];
      logic [WIDTH-1:0] expS[2];
      logic expC[2];
      int opIdx;
      logic accepting;
      expS[0] = 16'h0000; expC[0] = 1'b1;
      expS[1] = 16'h0002; expC[1] = 1'b0;
      cyc = 0;
      opIdx = 0;
      accepting = 1'b0;
      applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
      while (handshakes.size() < 2 && cyc < 60) begin
        if (op_valid && op_ready) begin
          accepts.push_back(cyc);
          accepting = 1'b1;
        end
        if (res_valid && res_ready) begin
          checkOutput($sformatf("b2b_sum%0d", handshakes.size()), sum, expS[handshakes.size()]);
          checkOutput($sformatf("b2b_cout%0d", handshakes.size()), cout, expC[handshakes.size()]);
          handshakes.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
        if (accepting) begin
          opIdx++;
          if (opIdx == 1) begin
            a = 16'h0001;
            b = 16'h0001;
          end else begin
            op_valid = 1'b0;
          end
          accepting = 1'b0;
        end
      end
      checkOutput("b2b_results", handshakes.size(), 2);
      checkOutput("b2b_accepts", accepts.size(), 2);
      checkOutput("b2b_gap", (accepts.size() >= 2 && handshakes.size() >= 1) ?
                  (accepts[1] - handshakes[0]) : -1, 1);
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
    end

    $display("[TB] randomized operations");
    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
`ifdef SUB_MODE_EN
      rsub = logic'($urandom_range(0, 1));
`else
      rsub = 1'b0;
`endif
      refModel(ra, rb, rsub, rs, rc);
      runOp(ra, rb, rsub, rs, rc, logic'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
